// File: rtl/hmac_arbiter.sv
// Round-robin arbiter that time-shares one hmac core between NUM_REQ requester lanes.
// Optional RUN-state watchdog is compiled in when HMAC_ARB_TIMEOUT_EN is defined.
module hmac_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    breset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      req_mode,
    input  logic [NUM_REQ*1024-1:0] req_key,
    input  logic [NUM_REQ*512-1:0]  req_msg,
    output logic [NUM_REQ-1:0]      ack,
    output logic [511:0]            result,
    output logic                    err,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    busy,
    output logic                    hmac_reset,
    output logic                    hmac_mode,
    output logic [1023:0]           hmac_key,
    output logic [511:0]            hmac_msg,
    input  logic                    hmac_done,
    input  logic [511:0]            hmac_out
);
    localparam int IdxW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [IdxW-1:0]    last_q, last_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               hmac_reset_q, hmac_reset_d;
    logic               hmac_mode_q, hmac_mode_d;
    logic [1023:0]      hmac_key_q, hmac_key_d;
    logic [511:0]       hmac_msg_q, hmac_msg_d;
    logic [511:0]       result_q, result_d;

    logic               win_found;
    logic [IdxW-1:0]    win_idx;
    logic [IdxW-1:0]    cand;
    logic               expired;

    // Scan starts one past the previous winner so priority rotates.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IdxW'((int'(last_q) + k) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef HMAC_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == LOAD) begin
            tmo_cnt_d = '0;
        end else if (state_q == RUN) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge breset) begin
        if (!breset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Counter holds k-1 during the k-th RUN cycle.
    assign expired = (state_q == RUN) && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        grant_d      = grant_q;
        ack_d        = '0;
        err_d        = 1'b0;
        hmac_reset_d = hmac_reset_q;
        hmac_mode_d  = hmac_mode_q;
        hmac_key_d   = hmac_key_q;
        hmac_msg_d   = hmac_msg_q;
        result_d     = result_q;
        unique case (state_q)
            IDLE: begin
                hmac_reset_d = 1'b0;
                if (win_found) begin
                    owner_d          = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    hmac_mode_d      = req_mode[win_idx];
                    hmac_key_d       = req_key[int'(win_idx)*1024 +: 1024];
                    hmac_msg_d       = req_msg[int'(win_idx)*512 +: 512];
                    state_d          = LOAD;
                end
            end
            LOAD: begin
                hmac_reset_d = 1'b1;
                state_d      = RUN;
            end
            RUN: begin
                if (hmac_done) begin
                    result_d     = hmac_out;
                    hmac_reset_d = 1'b0;
                    ack_d        = grant_q;
                    state_d      = DONE;
                end else if (expired) begin
                    result_d     = '0;
                    err_d        = 1'b1;
                    hmac_reset_d = 1'b0;
                    ack_d        = grant_q;
                    state_d      = DONE;
                end
            end
            DONE: begin
                last_d  = owner_q;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge breset) begin
        if (!breset) begin
            state_q      <= IDLE;
            last_q       <= IdxW'(NUM_REQ - 1);
            owner_q      <= '0;
            grant_q      <= '0;
            ack_q        <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            hmac_reset_q <= 1'b0;
            hmac_mode_q  <= 1'b0;
            hmac_key_q   <= '0;
            hmac_msg_q   <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            hmac_reset_q <= hmac_reset_d;
            hmac_mode_q  <= hmac_mode_d;
            hmac_key_q   <= hmac_key_d;
            hmac_msg_q   <= hmac_msg_d;
            result_q     <= result_d;
        end
    end

    assign ack        = ack_q;
    assign result     = result_q;
    assign err        = err_q;
    assign grant      = grant_q;
    assign busy       = busy_q;
    assign hmac_reset = hmac_reset_q;
    assign hmac_mode  = hmac_mode_q;
    assign hmac_key   = hmac_key_q;
    assign hmac_msg   = hmac_msg_q;

endmodule

// File: tb/tb_hmac_arbiter.sv
// Randomised bench for hmac_arbiter: behavioural requesters, a toy hmac core and a
// job-level reference model (rotating-priority pick, captured operands, expected latency).
module tb_hmac_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TMO     = 16;

    logic                    clk;
    logic                    breset;
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ-1:0]      req_mode;
    logic [NUM_REQ*1024-1:0] req_key;
    logic [NUM_REQ*512-1:0]  req_msg;
    logic [NUM_REQ-1:0]      ack;
    logic [511:0]            result;
    logic                    err;
    logic [NUM_REQ-1:0]      grant;
    logic                    busy;
    logic                    hmac_reset;
    logic                    hmac_mode;
    logic [1023:0]           hmac_key;
    logic [511:0]            hmac_msg;
    logic                    hmac_done;
    logic [511:0]            hmac_out;

    hmac_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .breset(breset), .req(req), .req_mode(req_mode), .req_key(req_key),
        .req_msg(req_msg), .ack(ack), .result(result), .err(err), .grant(grant), .busy(busy),
        .hmac_reset(hmac_reset), .hmac_mode(hmac_mode), .hmac_key(hmac_key),
        .hmac_msg(hmac_msg), .hmac_done(hmac_done), .hmac_out(hmac_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] hmac_fn(input logic m, input logic [1023:0] k,
                                             input logic [511:0] d);
        return d ^ k[511:0] ^ k[1023:512] ^ {512{m}};
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int w);
        logic [NUM_REQ-1:0] v;
        v = '0;
        if (w >= 0 && w < NUM_REQ) v[w] = 1'b1;
        return v;
    endfunction

    // Toy core: done in the N-th cycle after release from reset (N = 0: never).
    int core_delay = 3;
    int job_delay;
    int core_cnt;
    bit spurious   = 1'b0;

    always @(posedge clk or negedge breset) begin
        if (!breset) begin
            core_cnt  <= 0;
            job_delay <= 0;
        end else if (!hmac_reset) begin
            core_cnt  <= 0;
            job_delay <= core_delay;
        end else begin
            core_cnt <= core_cnt + 1;
        end
    end

    assign hmac_done = (hmac_reset && job_delay != 0 && core_cnt == job_delay - 1) ||
                       (!hmac_reset && spurious);
    assign hmac_out  = hmac_fn(hmac_mode, hmac_key, hmac_msg);

    // Reference model: one job = LOAD, RUN x len, DONE; sampled on the falling edge.
    int                      m_last = NUM_REQ - 1;
    bit                      in_job, after_done, prev_idle;
    int                      jcyc, exp_win, exp_len, last_job_len;
    bit                      exp_err, last_job_err;
    int                      jobs_done = 0;
    logic                    exp_mode;
    logic [1023:0]           exp_key;
    logic [511:0]            exp_msg, exp_res;
    logic [NUM_REQ-1:0]      p_req, p_mode;
    logic [NUM_REQ*1024-1:0] p_key;
    logic [NUM_REQ*512-1:0]  p_msg;
    int                      grant_log[$];
    int                      ack_cnt[NUM_REQ];

    always @(negedge clk) begin : monitor
        bit idle_now;
        idle_now = 1'b0;
        if (!breset) begin
            in_job     = 1'b0;
            after_done = 1'b0;
            m_last     = NUM_REQ - 1;
        end else if (after_done) begin
            check("gap_grant", grant, '0);
            check("gap_ack", ack, '0);
            check("gap_busy", busy, 1'b0);
            after_done = 1'b0;
            idle_now   = 1'b1;
        end else if (!in_job) begin
            if (grant != '0) begin
                exp_win = rr_pick(p_req, m_last);
                check("grant_win", grant, onehot(exp_win));
                if (exp_win >= 0) begin
                    exp_mode = p_mode[exp_win];
                    exp_key  = p_key[exp_win*1024 +: 1024];
                    exp_msg  = p_msg[exp_win*512 +: 512];
                end
                check("op_mode", hmac_mode, exp_mode);
                check("op_key_lo", hmac_key[511:0], exp_key[511:0]);
                check("op_key_hi", hmac_key[1023:512], exp_key[1023:512]);
                check("op_msg", hmac_msg, exp_msg);
                check("load_rst", hmac_reset, 1'b0);
                check("load_busy", busy, 1'b1);
`ifdef HMAC_ARB_TIMEOUT_EN
                exp_err = (core_delay == 0) || (core_delay > TMO);
`else
                exp_err = 1'b0;
`endif
                exp_len = exp_err ? TMO : core_delay;
                exp_res = exp_err ? '0 : hmac_fn(exp_mode, exp_key, exp_msg);
                grant_log.push_back(exp_win);
                in_job = 1'b1;
                jcyc   = 0;
            end else begin
                idle_now = 1'b1;
                check("idle_busy", busy, 1'b0);
                check("idle_ack", ack, '0);
                check("idle_rst", hmac_reset, 1'b0);
                if (prev_idle && p_req != '0)
                    check("grant_late", grant, onehot(rr_pick(p_req, m_last)));
            end
        end else begin
            jcyc++;
            if (ack != '0) begin
                check("ack_win", ack, onehot(exp_win));
                check("ack_cycle", 512'(jcyc), 512'(exp_len + 1));
                check("result", result, exp_res);
                check("err", err, exp_err);
                check("done_grant", grant, onehot(exp_win));
                check("done_rst", hmac_reset, 1'b0);
                for (int i = 0; i < NUM_REQ; i++) if (ack[i]) ack_cnt[i]++;
                last_job_len = jcyc + 1;
                last_job_err = err;
                m_last       = exp_win;
                jobs_done++;
                in_job     = 1'b0;
                after_done = 1'b1;
            end else begin
                check("hold_grant", grant, onehot(exp_win));
                check("hold_msg", hmac_msg, exp_msg);
                check("run_err", err, 1'b0);
                if (jcyc > exp_len) begin
                    check("ack_missing", ack, onehot(exp_win));
                    in_job = 1'b0;
                end else begin
                    check("run_rst", hmac_reset, 1'b1);
                end
            end
        end
        prev_idle = idle_now;
        p_req     = req;
        p_mode    = req_mode;
        p_key     = req_key;
        p_msg     = req_msg;
    end

    // Requester lanes: 0 = manual, 1 = random, 2 = re-raise after every ack.
    int                 kind[NUM_REQ];
    bit                 rand_mode = 1'b0;
    logic [NUM_REQ-1:0] s_grant;

    task automatic raise(input int i);
        req[i]      = 1'b1;
        req_mode[i] = 1'($urandom_range(0, 1));
        for (int w = 0; w < 32; w++) req_key[i*1024 + w*32 +: 32] = $urandom();
        for (int w = 0; w < 16; w++) req_msg[i*512 + w*32 +: 32] = $urandom();
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] seen;
        @(negedge clk);
        seen    = ack;
        s_grant = grant;
        @(posedge clk);
        #1;
        spurious = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (seen[i]) begin
                req[i] = 1'b0;
            end else if (kind[i] == 2 && !req[i]) begin
                raise(i);
            end else if (kind[i] == 1) begin
                if (!req[i] && $urandom_range(0, 3) == 0) raise(i);
                else if (req[i] && $urandom_range(0, 49) == 0) req[i] = 1'b0;
            end
        end
        if (rand_mode) begin
            spurious = ($urandom_range(0, 5) == 0);
            if (!busy) core_delay = $urandom_range(1, 12);
        end
    endtask

    task automatic wait_jobs(input int n, input int budget);
        int base;
        base = jobs_done;
        for (int c = 0; c < budget && jobs_done - base < n; c++) step();
        check("jobs_done", 512'(jobs_done - base), 512'(n));
    endtask

    task automatic wait_grant(input int idx, input int budget);
        s_grant = '0;
        for (int c = 0; c < budget && !s_grant[idx]; c++) step();
        check("wait_grant", s_grant, onehot(idx));
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && (req != '0 || busy); c++) step();
        check("drain_req", req, '0);
        check("drain_busy", busy, 1'b0);
    endtask

    task automatic apply_reset();
        breset = 1'b0;
        #1;
        check("rst_ack", ack, '0);
        check("rst_grant", grant, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_hreset", hmac_reset, 1'b0);
        check("rst_result", result, '0);
        check("rst_mode", hmac_mode, 1'b0);
        check("rst_key_lo", hmac_key[511:0], '0);
        check("rst_key_hi", hmac_key[1023:512], '0);
        check("rst_msg", hmac_msg, '0);
        repeat (2) step();
        breset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "simulation watchdog");
    end

    initial begin
        int            b, a3;
        logic          o_mode;
        logic [1023:0] o_key;
        logic [511:0]  o_msg;

        req      = '0;
        req_mode = '0;
        req_key  = '0;
        req_msg  = '0;
        for (int i = 0; i < NUM_REQ; i++) kind[i] = 0;
        apply_reset();

        // Single requester 2 with a 10-cycle core.
        core_delay = 10;
        req[2] = 1'b1;
        req_mode[2] = 1'b0;
        req_key[2*1024 +: 1024] = '0;
        req_msg[2*512 +: 512] = {64{8'hA5}};
        wait_jobs(1, 40);
        check("single_len", 512'(last_job_len), 512'(12));
        check("single_result", result, {64{8'hA5}});
        check("single_err", err, 1'b0);
        check("single_ackcnt", 512'(ack_cnt[2]), 512'(1));

        // Two simultaneous requests right after reset.
        apply_reset();
        core_delay = 3;
        b = grant_log.size();
        raise(0);
        raise(1);
        wait_jobs(2, 40);
        check("pair_first", 512'(grant_log[b]), 512'(0));
        check("pair_second", 512'(grant_log[b+1]), 512'(1));
        check("pair_ack0", 512'(ack_cnt[0]), 512'(1));
        check("pair_ack1", 512'(ack_cnt[1]), 512'(1));

        // All four held and re-raised: grants must rotate.
        apply_reset();
        b = grant_log.size();
        for (int i = 0; i < NUM_REQ; i++) begin
            kind[i] = 2;
            raise(i);
        end
        wait_jobs(8, 200);
        for (int i = 0; i < NUM_REQ; i++) kind[i] = 0;
        drain(200);
        for (int k = 0; k < 8; k++) check("rotate", 512'(grant_log[b+k]), 512'(k % NUM_REQ));

        // Operands change after grant; the running job keeps the captured ones.
        core_delay = 6;
        raise(1);
        o_mode = req_mode[1];
        o_key  = req_key[1024 +: 1024];
        o_msg  = req_msg[512 +: 512];
        wait_grant(1, 20);
        req_msg[512 +: 512] = '0;
        wait_jobs(1, 20);
        check("capture_result", result, hmac_fn(o_mode, o_key, o_msg));

        // Reset in the middle of requester 3's job.
        apply_reset();
        core_delay = 20;
        raise(3);
        wait_grant(3, 20);
        repeat (4) step();
        a3 = ack_cnt[3];
        apply_reset();
        raise(0);
        b = grant_log.size();
        wait_jobs(1, 40);
        check("rst_first_win", 512'(grant_log[b]), 512'(0));
        check("rst_no_stale", 512'(ack_cnt[3]), 512'(a3));
        drain(200);

        // Randomised traffic with spurious done pulses outside RUN.
        rand_mode = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) kind[i] = 1;
        repeat (600) step();
        for (int i = 0; i < NUM_REQ; i++) kind[i] = 0;
        rand_mode = 1'b0;
        drain(2000);

`ifdef HMAC_ARB_TIMEOUT_EN
        // Core never finishes: watchdog ends the job, then the next lane runs normally.
        apply_reset();
        core_delay = 0;
        b = grant_log.size();
        raise(2);
        raise(3);
        wait_grant(2, 20);
        core_delay = 5;
        wait_jobs(2, 100);
        check("tmo_order0", 512'(grant_log[b]), 512'(2));
        check("tmo_order1", 512'(grant_log[b+1]), 512'(3));
        check("tmo_next_len", 512'(last_job_len), 512'(7));
        check("tmo_next_err", 512'(last_job_err), 512'(0));
        // done on the expiry cycle wins; one cycle later loses
        core_delay = TMO;
        raise(1);
        wait_jobs(1, 60);
        check("tmo_edge_len", 512'(last_job_len), 512'(TMO + 2));
        check("tmo_edge_err", 512'(last_job_err), 512'(0));
        core_delay = TMO + 1;
        raise(1);
        wait_jobs(1, 60);
        check("tmo_late_len", 512'(last_job_len), 512'(TMO + 2));
        check("tmo_late_err", 512'(last_job_err), 512'(1));
        check("tmo_late_result", result, '0);
`else
        // Without the watchdog a long job simply runs to completion.
        core_delay = 40;
        raise(1);
        wait_jobs(1, 80);
        check("long_len", 512'(last_job_len), 512'(42));
        check("long_err", 512'(last_job_err), 512'(0));
`endif
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
